crdt_tx: RTL

CRDT_TX -- requirements
Module: crdt_tx

---
 rtl/crdt_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/crdt_tx.sv
// ---------------------------------------------------------------------------
// crdt_tx -- credit-based transmitter.
//
// Accepts words from an upstream valid/ready source and pushes them to a
// downstream receiver that has granted N credits. Every pushed word consumes
// one credit; the receiver hands credits back one at a time on crdt_rtn.
// A flush request stops new accepts and waits until every credit is home,
// then pulses flush_done for one cycle and resumes normal operation.
//
// Optional feature (macro CRDT_TX_OVF_CHK_EN):
//   defined   : a credit returned while all N are already home sets the
//               sticky err_ovf flag and the count saturates at N.
//   undefined : err_ovf is tied low; such a return is illegal stimulus and
//               is flagged by a simulation assertion.
//
// Parameters
//   W  data width in bits
//   N  credits granted by the receiver (power of 2)
//
// Ports
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   in_vld/in_data    upstream word
//   in_rdy            upstream word accepted when in_vld && in_rdy
//   push_vld          registered, word presented to the receiver
//   push_data         registered, word to the receiver
//   push_crdt_deduct  registered, credit consumed (equals push_vld)
//   crdt_rtn          one credit returned by the receiver
//   flush_req         request to drain all outstanding credits
//   flush_done        registered one-cycle pulse, all credits home
//   crdt_r            current credit count
//   err_ovf           sticky credit-overflow error
// ---------------------------------------------------------------------------
module crdt_tx #(
    parameter int W = 32,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [W-1:0]         in_data,
    output logic                 in_rdy,
    output logic                 push_vld,
    output logic [W-1:0]         push_data,
    output logic                 push_crdt_deduct,
    input  logic                 crdt_rtn,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic [$clog2(N):0]   crdt_r,
    output logic                 err_ovf
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CRDT_MAX = CW'(N);
    localparam logic [CW-1:0] CRDT_ONE = CW'(1);

    generate
        if (N < 1 || (N & (N - 1)) != 0) begin : g_bad_n
            $error("crdt_tx: N must be a power of 2");
        end
    endgenerate

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] crdt_q, crdt_d;
    logic          push_vld_q;
    logic [W-1:0]  push_data_q;
    logic          flush_done_q, flush_done_d;
    logic          accept;

    // Ready depends on registered state only, never on in_vld or crdt_rtn.
    assign in_rdy = (state_q == ST_ACTIVE) && (crdt_q != '0);
    assign accept = in_vld && in_rdy;

`ifdef CRDT_TX_OVF_CHK_EN
    logic err_ovf_q, err_ovf_d;

    always_comb begin
        crdt_d    = crdt_q;
        err_ovf_d = err_ovf_q;
        if (accept && !crdt_rtn) begin
            crdt_d = crdt_q - CRDT_ONE;
        end else if (!accept && crdt_rtn) begin
            if (crdt_q == CRDT_MAX) begin
                err_ovf_d = 1'b1;
            end else begin
                crdt_d = crdt_q + CRDT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
        end
    end

    assign err_ovf = err_ovf_q;
`else
    always_comb begin
        crdt_d = crdt_q;
        if (accept && !crdt_rtn) begin
            crdt_d = crdt_q - CRDT_ONE;
        end else if (!accept && crdt_rtn) begin
            crdt_d = crdt_q + CRDT_ONE;
        end
    end

    assign err_ovf = 1'b0;

    a_no_ovf: assert property (@(posedge clk) disable iff (rst)
        !(crdt_rtn && !accept && crdt_q == CRDT_MAX))
        else $error("crdt_tx: credit returned while all credits are home");
`endif

    // An accept in the same cycle as flush_req still goes out; FLUSH then
    // waits for that word's push to clear and its credit to come back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (flush_req) state_d = ST_FLUSH;
            ST_FLUSH:  if (crdt_q == CRDT_MAX && !push_vld_q) state_d = ST_DONE;
            ST_DONE:   state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
        flush_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACTIVE;
            crdt_q       <= CRDT_MAX;
            push_vld_q   <= 1'b0;
            push_data_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            crdt_q       <= crdt_d;
            push_vld_q   <= accept;
            flush_done_q <= flush_done_d;
            if (accept) begin
                push_data_q <= in_data;
            end
        end
    end

    assign push_vld         = push_vld_q;
    assign push_crdt_deduct = push_vld_q;
    assign push_data        = push_data_q;
    assign flush_done       = flush_done_q;
    assign crdt_r           = crdt_q;

endmodule
